// File: rtl/distance_display_ctrl_pkg.sv
// Shared types and constants for the distance display controller.
// Holds the converter state enum and the double-dabble adjust helper.
package distance_display_ctrl_pkg;

   localparam int NUM_DIGITS   = 4;
   localparam int VALUE_W      = 14;
   localparam int SHIFT_CYCLES = 14;
   localparam int BCD_W        = 4 * NUM_DIGITS;

   localparam logic [VALUE_W-1:0] VALUE_MAX = 14'd9999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   // Add 3 to every BCD nibble that is 5 or more.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int n = 0; n < NUM_DIGITS; n++) begin
         if (a[4*n +: 4] >= 4'd5) begin
            r[4*n +: 4] = a[4*n +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/distance_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD, 14 SHIFT steps, COMMIT.
// The sampled value is clamped to 9999 and the clamp is flagged.
import distance_display_ctrl_pkg::*;

module bin2bcd_seq (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [VALUE_W-1:0] i_Value,
   input  logic               i_Valid,
   output logic [BCD_W-1:0]   o_Acc,
   output logic               o_Ovf,
   output logic               o_Commit,
   output logic               o_BusyNext
);

   localparam logic [3:0] CNT_LAST = 4'(SHIFT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [VALUE_W-1:0] val_q, val_d;
   logic [VALUE_W-1:0] sr_q, sr_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               commit;

   // State and datapath registers.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= IDLE;
         val_q   <= '0;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath step for each converter state.
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_Valid) begin
               val_d   = i_Value;
               state_d = LOAD;
            end
         end
         LOAD: begin
            ovf_d   = (val_q > VALUE_MAX);
            sr_d    = (val_q > VALUE_MAX) ? VALUE_MAX : val_q;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            {acc_d, sr_d} = {dd_adjust(acc_q), sr_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_Acc      = acc_q;
   assign o_Ovf      = ovf_q;
   assign o_Commit   = commit;
   assign o_BusyNext = (state_d != IDLE);

endmodule

// File: rtl/distance_display_ctrl.sv
// Four-digit multiplexed distance display with sequential BCD conversion.
// Digits only update on commit; scan and blanking run continuously.
import distance_display_ctrl_pkg::*;

module distance_display_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [VALUE_W-1:0] i_Value,
   input  logic               i_Valid,
   output logic [3:0]         o_Bcd,
   output logic [3:0]         o_Sel,
   output logic               o_Busy,
   output logic               o_Done,
   output logic               o_Ovf,
   output logic               o_Drop
);

   localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

   logic [BCD_W-1:0] conv_acc;
   logic             conv_ovf;
   logic             conv_commit;
   logic             conv_busy_d;

   logic [19:0]      cnt_q;
   logic [1:0]       idx_q;
   logic [BCD_W-1:0] digits_q;
   logic             busy_q, done_q, ovf_q, drop_q;
   logic [3:0]       bcd_q, sel_q;

   logic [NUM_DIGITS-1:0] blank;
   logic                  zero_above;
   logic [3:0]            bcd_d, sel_d;

   bin2bcd_seq u_conv (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Value    (i_Value),
      .i_Valid    (i_Valid),
      .o_Acc      (conv_acc),
      .o_Ovf      (conv_ovf),
      .o_Commit   (conv_commit),
      .o_BusyNext (conv_busy_d)
   );

   // Free-running scan counter and digit index.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == SCAN_LAST) begin
         cnt_q <= '0;
         idx_q <= idx_q + 2'd1;
      end else begin
         cnt_q <= cnt_q + 20'd1;
      end
   end

   // Displayed digits and status flags, updated from the converter.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         digits_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         busy_q <= conv_busy_d;
         done_q <= conv_commit;
         drop_q <= i_Valid && busy_q;
         if (conv_commit) begin
            digits_q <= conv_acc;
            ovf_q    <= conv_ovf;
         end
      end
   end

   // Leading-zero blanking and selection of the scanned digit.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
         zero_above = zero_above && (digits_q[4*n +: 4] == 4'd0);
         blank[n]   = BLANK_LZ && zero_above;
      end
      bcd_d = digits_q[{idx_q, 2'b00} +: 4];
      sel_d = blank[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
   end

   // Registered display outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         bcd_q <= '0;
         sel_q <= 4'b1111;
      end else begin
         bcd_q <= bcd_d;
         sel_q <= sel_d;
      end
   end

   assign o_Bcd  = bcd_q;
   assign o_Sel  = sel_q;
   assign o_Busy = busy_q;
   assign o_Done = done_q;
   assign o_Ovf  = ovf_q;
   assign o_Drop = drop_q;

endmodule

// File: tb/tb_distance_display_ctrl.sv
// Directed bench for distance_display_ctrl with a fast scan.
// Expected values are hand-computed per vector.
module tb_distance_display_ctrl;

   logic        clk;
   logic        rst;
   logic [13:0] value;
   logic        valid;
   logic [3:0]  bcd, sel;
   logic        busy, done, ovf, drop;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   distance_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .i_Clk   (clk),
      .i_Rst   (rst),
      .i_Value (value),
      .i_Valid (valid),
      .o_Bcd   (bcd),
      .o_Sel   (sel),
      .o_Busy  (busy),
      .o_Done  (done),
      .o_Ovf   (ovf),
      .o_Drop  (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic start(input logic [13:0] v);
      valid = 1'b1;
      value = v;
      cyc   = 0;
      step();
      valid = 1'b0;
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
         step();
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sel"}, sel, 4'b1111);
      chk({tag, "_bcd"}, bcd, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_drop"}, drop, 0);
   endtask

   task automatic scan_chk(input string tag, input logic [15:0] dig,
                           input logic [3:0] seen_exp);
      logic [3:0] seen;
      int nblank;
      int nexp;
      seen   = '0;
      nblank = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         case (sel)
            4'b1110: begin seen[0] = 1'b1; chk({tag, "_d0"}, bcd, dig[3:0]); end
            4'b1101: begin seen[1] = 1'b1; chk({tag, "_d1"}, bcd, dig[7:4]); end
            4'b1011: begin seen[2] = 1'b1; chk({tag, "_d2"}, bcd, dig[11:8]); end
            4'b0111: begin seen[3] = 1'b1; chk({tag, "_d3"}, bcd, dig[15:12]); end
            4'b1111: nblank++;
            default: chk({tag, "_sel_legal"}, sel, 4'b1110);
         endcase
      end
      nexp = 4 * (4 - $countones(seen_exp));
      chk({tag, "_seen"}, seen, seen_exp);
      chk({tag, "_nblank"}, nblank, nexp);
   endtask

   int         at;
   int         ndone;
   logic       found;
   logic [3:0] prev;
   logic [3:0] exp_sel;
   logic [15:0] d5678;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      value = '0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;
      step();
      chk("rel_sel", sel, 4'b1110);
      chk("rel_bcd", bcd, 0);

      // 1234: latency, single done, digits 4,3,2,1
      start(14'd1234);
      chk("c1234_busy", busy, 1);
      wait_done(at);
      chk("c1234_lat", at, 17);
      chk("c1234_ovf", ovf, 0);
      chk("c1234_busy_idle", busy, 0);
      step();
      chk("c1234_done_once", done, 0);
      scan_chk("s1234", 16'h1234, 4'b1111);

      // 7: only digit 0 enabled
      start(14'd7);
      wait_done(at);
      chk("c7_lat", at, 17);
      scan_chk("s7", 16'h0007, 4'b0001);

      // 12000 saturates, then 5 clears overflow
      start(14'd12000);
      wait_done(at);
      chk("c12k_lat", at, 17);
      chk("c12k_ovf", ovf, 1);
      scan_chk("s12k", 16'h9999, 4'b1111);
      chk("c12k_ovf_hold", ovf, 1);
      start(14'd5);
      while (cyc < 16) step();
      chk("c5_ovf_before", ovf, 1);
      wait_done(at);
      chk("c5_lat", at, 17);
      chk("c5_ovf", ovf, 0);
      scan_chk("s5", 16'h0005, 4'b0001);

      // 42 then 99 at cycle 5: dropped
      start(14'd42);
      while (cyc < 5) step();
      valid = 1'b1;
      value = 14'd99;
      chk("drop_c5", drop, 0);
      step();
      valid = 1'b0;
      chk("drop_c6", drop, 1);
      step();
      chk("drop_c7", drop, 0);
      wait_done(at);
      chk("c42_lat", at, 17);
      scan_chk("s42", 16'h0042, 4'b0011);

      // valid in COMMIT dropped, valid in first IDLE accepted
      start(14'd321);
      while (cyc < 16) step();
      chk("cm_busy", busy, 1);
      valid = 1'b1;
      value = 14'd888;
      step();
      chk("cm_done", done, 1);
      chk("cm_drop", drop, 1);
      chk("cm_idle", busy, 0);
      value = 14'd55;
      step();
      valid = 1'b0;
      chk("cm_accept", busy, 1);
      chk("cm_nodrop", drop, 0);
      wait_done(at);
      chk("c55_lat", at, 34);
      scan_chk("s55", 16'h0055, 4'b0011);

      // 5678: scan period of 4 clocks per digit
      start(14'd5678);
      wait_done(at);
      chk("c5678_lat", at, 17);
      step();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         prev = sel;
         step();
         if (sel == 4'b1110 && prev != 4'b1110) begin
            found = 1'b1;
            break;
         end
      end
      chk("scan_sync", found, 1);
      d5678 = 16'h5678;
      for (int i = 0; i < 16; i++) begin
         exp_sel = ~(4'b0001 << (i / 4));
         chk("scan_sel", sel, exp_sel);
         chk("scan_bcd", bcd, d5678[4*(i/4) +: 4]);
         step();
      end

      // reset during SHIFT cycle 7 of 9999
      start(14'd9999);
      while (cyc < 8) step();
      chk("abort_busy", busy, 1);
      rst = 1'b1;
      step();
      chk_reset("abort1");
      step();
      chk_reset("abort2");
      rst = 1'b0;
      step();
      chk("abort_sel", sel, 4'b1110);
      chk("abort_bcd", bcd, 0);
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         if (done === 1'b1) ndone++;
         step();
      end
      chk("abort_nodone", ndone, 0);
      scan_chk("s_abort", 16'h0000, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/distance_display_ctrl.md
DISTANCE_DISPLAY_CTRL -- requirements
Module: distance_display_ctrl

Interface
REQ-001 Parameter SCAN_DIV, 50000, clock cycles each digit is enabled during the display scan (range 2..2^20).
REQ-002 Parameter BLANK_LZ, 1, enables leading-zero blanking when 1.
REQ-003 i_Clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 i_Rst  in  1  reset, synchronous and active-high.
REQ-005 i_Value  in  14  unsigned binary distance to display.
REQ-006 i_Valid  in  1  one-cycle strobe; i_Value is sampled when it is high.
REQ-007 o_Bcd  out  4  BCD digit currently scanned; drives the shared 7-segment decoder.
REQ-008 o_Sel  out  4  active-low one-hot digit enable; bit n selects digit n, where digit 0 is the least significant.
REQ-009 o_Busy  out  1  high while a conversion is in progress.
REQ-010 o_Done  out  1  one-cycle pulse when new digits become visible.
REQ-011 o_Ovf  out  1  high while the displayed value is saturated.
REQ-012 o_Drop  out  1  one-cycle pulse when i_Valid arrives while o_Busy is high.

Function
REQ-013 The converter FSM shall have the states IDLE, LOAD, SHIFT and COMMIT, with the following transitions.
  - IDLE->LOAD on i_Valid.
  - LOAD->SHIFT unconditionally.
  - SHIFT->COMMIT after exactly 14 SHIFT cycles.
  - COMMIT->IDLE unconditionally.
REQ-014 LOAD shall capture min(i_Value, 9999).
  - o_Ovf shall be loaded with (i_Value > 9999) and held until the next COMMIT.
REQ-015 Each SHIFT cycle shall perform one double-dabble step on a 16-bit BCD accumulator and a 14-bit shift register, MSB first.
  - First, every nibble >= 5 shall have 3 added to it.
  - Then the concatenated accumulator and shift register shall shift left by one bit.
REQ-016 COMMIT shall copy the accumulator into the four displayed-digit registers and assert o_Done in that same cycle.
REQ-017 Latency from the edge that samples i_Valid to the o_Done cycle shall be exactly 16 clocks.
  - The new digits shall appear on o_Bcd from the next edge onward.
REQ-018 o_Busy shall be high in LOAD, SHIFT and COMMIT, and low in IDLE.
REQ-019 An i_Valid that arrives while o_Busy is high shall be discarded and shall pulse o_Drop in the following cycle.
  - The conversion in progress shall be unaffected.
REQ-020 An i_Valid in the same cycle as COMMIT shall be dropped; an i_Valid in the first IDLE cycle after COMMIT shall be accepted.
REQ-021 The displayed-digit registers shall change only in COMMIT, so the scan never shows a partially converted value.
REQ-022 The scan counter shall count 0..SCAN_DIV-1 and wrap to 0.
  - On each wrap, the digit index shall advance 0->1->2->3->0.
  - The scan shall run continuously, independent of the converter FSM.
REQ-023 o_Bcd shall equal the displayed digit at the current index.
  - o_Sel shall drive low only the bit of the current index, unless that digit is blanked.
REQ-024 When BLANK_LZ=1, digit n (n>=1) shall be blanked when it and all higher digits are zero.
  - A blanked digit shall hold o_Sel at 4'b1111 for its slot.
  - Digit 0 shall never be blanked.
REQ-025 All outputs shall be registered; there shall be no combinational path from any input to any output.

Reset
REQ-026 While i_Rst is high, the block shall hold the following values.
  - FSM in IDLE.
  - Accumulator, shift register and displayed digits at 0.
  - Scan counter and digit index at 0.
  - o_Sel=4'b1111, o_Bcd=0.
  - o_Busy, o_Done, o_Ovf and o_Drop at 0.
REQ-027 Reset asserted mid-conversion shall abort the conversion; the displayed digits shall read 0 and no o_Done shall be issued.
REQ-028 In the first cycle after reset release, the block shall show digit 0 with o_Sel=4'b1110 and o_Bcd=0.

Structure
REQ-029 A shared package shall hold the FSM state enum and the following constants.
  - NUM_DIGITS=4.
  - VALUE_W=14.
  - VALUE_MAX=9999.
  - SHIFT_CYCLES=14.
REQ-030 The double-dabble converter (LOAD/SHIFT/COMMIT datapath and FSM) shall be a sub-module named bin2bcd_seq.
  - The scan counter, blanking and output registers shall stay in the top module.

Verification
REQ-031 i_Value=1234 with i_Valid for 1 cycle, then 16 clocks -> o_Done pulses once and the digits scanned are 4,3,2,1 with o_Ovf=0.
REQ-032 i_Value=7 with BLANK_LZ=1 -> only digit 0 is enabled (o_Sel=4'b1110 in slot 0, 4'b1111 in slots 1-3) and o_Bcd=7.
REQ-033 i_Value=12000 -> digits 9,9,9,9 with o_Ovf=1; then i_Value=5 -> o_Ovf=0 at the o_Done of the second conversion.
REQ-034 i_Valid with 42 at cycle 0 and with 99 at cycle 5 -> o_Drop pulses at cycle 6 and the display shows 42.
REQ-035 Reset asserted at SHIFT cycle 7 of a 9999 conversion -> no o_Done, digits read 0, and o_Sel=4'b1110 after release.
REQ-036 SCAN_DIV=4 with a static value of 5678 -> o_Sel cycles 1110,1101,1011,0111 every 4 clocks and o_Bcd follows 8,7,6,5.
